// File: rtl/multi_key_debounce_pkg.sv
// Shared types and width helpers for the key debounce block.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   // Counter/code width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_key_debounce_if.sv
// Key conditioner bus: sample controls in, conditioned per-key events out.
interface multi_key_debounce_if #(parameter int NUM_KEYS = 4);
   import key_pkg::*;

   localparam int CODE_W = clog2_min1(NUM_KEYS);

   logic                tick;
   logic                rpt_en;
   logic [NUM_KEYS-1:0] key_in;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] press_pulse;
   logic [NUM_KEYS-1:0] release_pulse;
   logic                any_press;
   logic [CODE_W-1:0]   key_code;

   modport master (
      output tick, rpt_en, key_in,
      input  key_level, press_pulse, release_pulse, any_press, key_code
   );

   modport slave (
      input  tick, rpt_en, key_in,
      output key_level, press_pulse, release_pulse, any_press, key_code
   );
endinterface

// File: rtl/multi_key_debounce_channel.sv
// One key: 2-flop synchroniser, tick-gated debounce FSM and auto-repeat counter.
//   state        | meaning
//   IDLE         | released and stable
//   PRESS_WAIT   | counting consecutive pressed samples
//   HELD         | press accepted, auto-repeat timing runs here
//   RELEASE_WAIT | counting consecutive released samples
module key_channel
   import key_pkg::*;
#(
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic rpt_en,
   input  logic key_in,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse
);
   localparam int CNT_W  = clog2_min1(STABLE_CNT + 1);
   localparam int RCNT_W = clog2_min1(REPEAT_DELAY + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CNT - 1);
   localparam logic [RCNT_W-1:0] RCNT_LAST   = RCNT_W'(REPEAT_DELAY - 1);
   // A rate slower than the delay degenerates to one pulse per delay period.
   localparam logic [RCNT_W-1:0] RCNT_RELOAD =
      (REPEAT_RATE >= REPEAT_DELAY) ? RCNT_W'(0) : RCNT_W'(REPEAT_DELAY - REPEAT_RATE);

   logic [1:0]        sync_q;
   logic              s;
   key_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [RCNT_W-1:0] rcnt, rcnt_nxt;
   logic              press_nxt, release_nxt, level_nxt;

   assign s = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q        <= '0;
         state         <= IDLE;
         cnt           <= '0;
         rcnt          <= '0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], key_in};
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         rcnt          <= rcnt_nxt;
         key_level     <= level_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            IDLE:         if (s) state_nxt = PRESS_WAIT;
            PRESS_WAIT:   if (!s) state_nxt = IDLE;
                          else if (cnt == CNT_LAST) state_nxt = HELD;
            HELD:         if (!s) state_nxt = RELEASE_WAIT;
            RELEASE_WAIT: if (s) state_nxt = HELD;
                          else if (cnt == CNT_LAST) state_nxt = IDLE;
            default:      state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_nxt     = cnt;
      rcnt_nxt    = rcnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      if (tick) begin
         case (state)
            IDLE: if (s) cnt_nxt = CNT_W'(1);
            PRESS_WAIT: begin
               if (!s) cnt_nxt = '0;
               else if (cnt == CNT_LAST) begin
                  press_nxt = 1'b1;
                  cnt_nxt   = '0;
                  rcnt_nxt  = '0;
               end else cnt_nxt = cnt + CNT_W'(1);
            end
            HELD: begin
               if (!s) cnt_nxt = CNT_W'(1);
               else if (!rpt_en) rcnt_nxt = '0;
               else if (rcnt >= RCNT_LAST) begin
                  press_nxt = 1'b1;
                  rcnt_nxt  = RCNT_RELOAD;
               end else rcnt_nxt = rcnt + RCNT_W'(1);
            end
            RELEASE_WAIT: begin
               if (s) cnt_nxt = '0;
               else if (cnt == CNT_LAST) begin
                  release_nxt = 1'b1;
                  cnt_nxt     = '0;
               end else cnt_nxt = cnt + CNT_W'(1);
            end
            default: cnt_nxt = '0;
         endcase
      end
      level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
   end

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel key conditioner: per-key debounce channels plus lowest-index press encoder.
module multi_key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 3
) (
   input logic                 clk,
   input logic                 reset,
   multi_key_debounce_if.slave bus
);
   localparam int CODE_W = clog2_min1(NUM_KEYS);

   logic [NUM_KEYS-1:0] level_v, press_v, release_v;
   logic [CODE_W-1:0]   code;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_channel #(
         .STABLE_CNT  (STABLE_CNT),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .tick         (bus.tick),
         .rpt_en       (bus.rpt_en),
         .key_in       (bus.key_in[k]),
         .key_level    (level_v[k]),
         .press_pulse  (press_v[k]),
         .release_pulse(release_v[k])
      );
   end

   // Scan from the top so the lowest set index wins.
   always_comb begin
      code = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (press_v[k]) code = CODE_W'(k);
      end
   end

   assign bus.key_level     = level_v;
   assign bus.press_pulse   = press_v;
   assign bus.release_pulse = release_v;
   assign bus.any_press     = |press_v;
   assign bus.key_code      = code;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed scenarios plus random traffic against a run-length reference model of the key conditioner.
module tb_multi_key_debounce;
   import key_pkg::*;

   localparam int NK = 4;
   localparam int SC = 4;
   localparam int RD = 8;
   localparam int RR = 3;
   localparam int EXP_REP[8] = '{6, 14, 17, 20, 23, 26, 29, 32};

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multi_key_debounce_if #(.NUM_KEYS(NK)) bus ();

   multi_key_debounce #(
      .NUM_KEYS(NK), .STABLE_CNT(SC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Reference: accepted level, run of disagreeing samples, repeat tick count.
   logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
   int m_run[NK];
   int m_rep[NK];

   int n_pass = 0;
   int n_total = 0;
   int tick_period = 1;
   int tick_ph = 0;
   int cnt_press[NK];
   int cnt_rel[NK];

   function automatic int lowest(input logic [NK-1:0] v);
      for (int k = 0; k < NK; k++) if (v[k]) return k;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_edge();
      logic [NK-1:0] s;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
         for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_rep[k] = 0; end
      end else begin
         s = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.key_in;
         m_press = '0;
         m_rel = '0;
         if (bus.tick) begin
            for (int k = 0; k < NK; k++) begin
               if (s[k] != m_lvl[k]) begin
                  m_run[k]++;
                  if (m_run[k] == SC) begin
                     m_lvl[k] = s[k];
                     m_run[k] = 0;
                     if (s[k]) begin m_press[k] = 1'b1; m_rep[k] = 0; end
                     else m_rel[k] = 1'b1;
                  end
               end else if (m_run[k] > 0) begin
                  m_run[k] = 0;
               end else if (m_lvl[k]) begin
                  if (!bus.rpt_en) m_rep[k] = 0;
                  else begin
                     m_rep[k]++;
                     if (m_rep[k] >= RD) begin m_press[k] = 1'b1; m_rep[k] = RD - RR; end
                  end
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("key_level", 32'(bus.key_level), 32'(m_lvl));
      chk("press_pulse", 32'(bus.press_pulse), 32'(m_press));
      chk("release_pulse", 32'(bus.release_pulse), 32'(m_rel));
      chk("any_press", 32'(bus.any_press), 32'(|m_press));
      chk("key_code", 32'(bus.key_code), 32'(lowest(m_press)));
      for (int k = 0; k < NK; k++) begin
         cnt_press[k] += int'(bus.press_pulse[k]);
         cnt_rel[k]   += int'(bus.release_pulse[k]);
      end
   endtask

   task automatic step();
      if (tick_period == 0) bus.tick = 1'($urandom_range(0, 1));
      else begin
         bus.tick = (tick_ph == 0);
         tick_ph = (tick_ph + 1) % tick_period;
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NK; k++) begin cnt_press[k] = 0; cnt_rel[k] = 0; end
   endtask

   // Always runs max steps; lat = step index of first pulse, -1 if none.
   task automatic wait_pulse(input int k, input bit rel, input int max, output int lat);
      lat = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         if (lat < 0 && (rel ? bus.release_pulse[k] : bus.press_pulse[k])) lat = i;
      end
   endtask

   int lat;
   int code_at;
   int rep_q[$];
   logic [NK-1:0] p5;
   logic a5;
   logic [1:0] c5;

   initial begin
      bus.key_in = '0;
      bus.rpt_en = 1'b0;
      bus.tick = 1'b0;
      clear_counts();
      reset = 1'b1;
      run(2);
      chk("reset_level", 32'(bus.key_level), 32'd0);
      chk("reset_press", 32'(bus.press_pulse), 32'd0);
      reset = 1'b0;
      tick_period = 1;
      run(4);

      // 1: single press, repeat off
      clear_counts();
      bus.key_in[2] = 1'b1;
      lat = -1; code_at = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (lat < 0 && bus.press_pulse[2]) begin lat = i; code_at = int'(bus.key_code); end
      end
      chk("s1_latency", 32'(lat), 32'd6);
      chk("s1_key_code", 32'(code_at), 32'd2);
      chk("s1_level_held", 32'(bus.key_level[2]), 32'd1);
      bus.key_in[2] = 1'b0;
      run(10);
      chk("s1_press_count", 32'(cnt_press[2]), 32'd1);
      chk("s1_release_count", 32'(cnt_rel[2]), 32'd1);

      // 2: short bounce is rejected
      clear_counts();
      bus.key_in[0] = 1'b1; step();
      bus.key_in[0] = 1'b0; step();
      bus.key_in[0] = 1'b1; step();
      bus.key_in[0] = 1'b0;
      run(10);
      chk("s2_press_count", 32'(cnt_press[0]), 32'd0);
      chk("s2_release_count", 32'(cnt_rel[0]), 32'd0);

      // 3: slow tick, every 6th clock
      clear_counts();
      tick_period = 6; tick_ph = 0;
      bus.key_in[1] = 1'b1;
      wait_pulse(1, 1'b0, 60, lat);
      chk("s3_press_latency", 32'(lat), 32'd25);
      bus.key_in[1] = 1'b0;
      wait_pulse(1, 1'b1, 60, lat);
      chk("s3_release_latency", 32'(lat), 32'd25);
      chk("s3_press_count", 32'(cnt_press[1]), 32'd1);

      // 4: auto-repeat cadence
      tick_period = 1; tick_ph = 0;
      bus.rpt_en = 1'b1;
      bus.key_in[3] = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus.press_pulse[3]) rep_q.push_back(i);
         if (i == 30) bus.key_in[3] = 1'b0;
      end
      chk("s4_repeat_count", 32'(rep_q.size()), 32'd8);
      for (int j = 0; j < 8; j++) begin
         if (j < rep_q.size()) chk("s4_repeat_at", 32'(rep_q[j]), 32'(EXP_REP[j]));
      end
      bus.rpt_en = 1'b0;

      // 5: simultaneous presses
      bus.key_in = 4'b1001;
      p5 = '0; a5 = 1'b0; c5 = 2'd3;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 6) begin p5 = bus.press_pulse; a5 = bus.any_press; c5 = bus.key_code; end
      end
      chk("s5_press_vec", 32'(p5), 32'h9);
      chk("s5_any_press", 32'(a5), 32'd1);
      chk("s5_key_code", 32'(c5), 32'd0);
      bus.key_in = '0;
      run(10);

      // 6: reset while a key is held
      bus.key_in[1] = 1'b1;
      run(10);
      reset = 1'b1;
      step();
      chk("s6_level_after_reset", 32'(bus.key_level), 32'd0);
      chk("s6_release_after_reset", 32'(bus.release_pulse), 32'd0);
      reset = 1'b0;
      clear_counts();
      wait_pulse(1, 1'b0, 10, lat);
      chk("s6_repress_latency", 32'(lat), 32'd6);
      chk("s6_no_release", 32'(cnt_rel[1]), 32'd0);
      bus.key_in[1] = 1'b0;
      run(10);

      // Random traffic: random tick, then every-clock tick with repeat on
      tick_period = 0;
      for (int i = 0; i < 500; i++) begin
         for (int k = 0; k < NK; k++) if ($urandom_range(0, 7) == 0) bus.key_in[k] = ~bus.key_in[k];
         if ($urandom_range(0, 63) == 0) bus.rpt_en = ~bus.rpt_en;
         reset = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 1'b0;
      tick_period = 1; tick_ph = 0;
      bus.rpt_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < NK; k++) if ($urandom_range(0, 19) == 0) bus.key_in[k] = ~bus.key_in[k];
         if ($urandom_range(0, 99) == 0) bus.rpt_en = ~bus.rpt_en;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
